// File: rtl/pdm_speaker_tx_pkg.sv
// pdm_speaker_tx_pkg
//   Shared constants for the PDM speaker transmitter: default PCM sample
//   width, decimation ratio (PDM ticks per PCM sample), the offset that maps
//   a signed sample onto the unsigned accumulator range, and the default
//   sample FIFO depth.
package pdm_speaker_tx_pkg;

    localparam int unsigned PCM_WIDTH  = 16;
    localparam int unsigned PDM_DECIM  = 125;
    localparam int unsigned PDM_OFFSET = 32768;
    localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/pdm_speaker_tx_if.sv
// pdm_speaker_tx_if
//   PCM sample write port of the PDM speaker transmitter.
//   dat_i : signed PCM sample          (master -> slave)
//   dv_i  : one-cycle write strobe     (master -> slave)
//   ready : FIFO not full              (slave -> master)
//   level : FIFO occupancy, 0..DEPTH   (slave -> master)
interface pdm_speaker_tx_if
    import pdm_speaker_tx_pkg::*;
#(
    parameter int unsigned WIDTH = PCM_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) ();

    logic signed [WIDTH-1:0]      dat_i;
    logic                         dv_i;
    logic                         ready;
    logic [$clog2(DEPTH):0]       level;

    modport master (output dat_i, output dv_i, input ready, input level);
    modport slave  (input dat_i, input dv_i, output ready, output level);

endinterface

// File: rtl/pdm_speaker_tx_pcm_fifo.sv
// pcm_fifo
//   Small synchronous FIFO for PCM samples.
//   clk, reset : clock, synchronous active-high reset
//   wr, wdata  : write strobe and data (caller guarantees space or a pop)
//   pop        : remove the head entry (caller guarantees non-empty)
//   head       : current head entry
//   count      : occupancy, 0..DEPTH
// Write and pop in the same cycle are allowed even when full.
module pcm_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic signed [WIDTH-1:0]    wdata,
    input  logic                       pop,
    output logic signed [WIDTH-1:0]    head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/pdm_speaker_tx.sv
// pdm_speaker_tx
//   First-order PDM modulator driving a speaker/amplifier from buffered PCM.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   sclk     : divided PDM bit clock level, sampled in the clk domain
//   pcm      : sample write port (dat_i, dv_i, ready, level)
//   sclk_o   : sclk delayed one clk cycle
//   pdm_o    : PDM bitstream, updated once per sclk period
//   underrun : sticky, a sample was due while the FIFO was empty
//   overflow : sticky, a write was dropped
module pdm_speaker_tx
    import pdm_speaker_tx_pkg::*;
#(
    parameter int unsigned WIDTH = PCM_WIDTH,
    parameter int unsigned DECIM = PDM_DECIM,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    pdm_speaker_tx_if.slave     pcm,
    output logic                sclk_o,
    output logic                pdm_o,
    output logic                underrun,
    output logic                overflow
);

    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [PW-1:0]           phase;
    logic signed [WIDTH-1:0] cur;
    logic signed [WIDTH-1:0] head;
    logic signed [WIDTH-1:0] sample;
    logic [15:0]             acc;
    logic [15:0]             u;
    logic [16:0]             s;
    logic [LW-1:0]           count;
    logic                    tick;
    logic                    load;
    logic                    empty;
    logic                    pop;
    logic                    wr;

    // sclk_o doubles as the edge-detect register: a tick is the cycle where
    // sclk is high and its registered copy is still low.
    assign tick  = sclk & ~sclk_o & ~reset;
    assign load  = tick & (phase == PW'(DECIM - 1));
    assign empty = (count == '0);
    assign pop   = load & ~empty;
    assign wr    = pcm.dv_i & ~reset & ((count != LW'(DEPTH)) | pop);

    pcm_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .wdata (pcm.dat_i),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    // On a load tick the modulator already uses the freshly loaded value.
    always_comb begin
        sample = cur;
        if (load) begin
            sample = empty ? '0 : head;
        end
        u = 16'(sample) + 16'(PDM_OFFSET);
        s = {1'b0, acc} + {1'b0, u};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_o   <= 1'b0;
            pdm_o    <= 1'b0;
            acc      <= '0;
            cur      <= '0;
            phase    <= PW'(DECIM - 1);
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sclk_o <= sclk;
            if (tick) begin
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
                pdm_o <= s[16];
                acc   <= s[15:0];
            end
            if (load) begin
                cur <= sample;
            end
            if (load && empty) begin
                underrun <= 1'b1;
            end
            if (pcm.dv_i && !wr) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pcm.level = count;
    assign pcm.ready = (count != LW'(DEPTH));

endmodule

// File: doc/pdm_speaker_tx.md
PDM_SPEAKER_TX -- requirements
Module: pdm_speaker_tx

Interface
REQ-001 Parameter WIDTH, default 16, signed PCM sample width.
REQ-002 Parameter DECIM, default 125, PDM ticks per PCM sample (2 MHz / 125 = 16 kHz).
REQ-003 Parameter DEPTH, default 4, sample FIFO depth; power of two, at least 2.
REQ-004 Ports, clock and reset first:
- clk  in  1  global clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  2 MHz divided clock level, sampled in the clk domain.
- dat_i  in  WIDTH  signed PCM sample.
- dv_i  in  1  one-cycle write strobe for dat_i.
- ready  out  1  high when the FIFO is not full.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- sclk_o  out  1  registered copy of sclk, for the amplifier or speaker.
- pdm_o  out  1  PDM bitstream.
- underrun  out  1  sticky; a sample was due while the FIFO was empty.
- overflow  out  1  sticky; a write was dropped.

Function
REQ-005 A tick is the clk cycle after sclk is seen low in one cycle and high in the next, using a registered copy; there is exactly one tick per sclk period.
REQ-006 sclk_o is sclk delayed by one clk cycle.
REQ-007 FIFO write: when dv_i=1, dat_i is stored if level<DEPTH or if a pop occurs in the same cycle.
- Otherwise the sample is dropped and overflow is set.
REQ-008 A phase counter counts 0..DECIM-1; it advances only on ticks and wraps from DECIM-1 to 0.
REQ-009 Load: on a tick with phase==DECIM-1, cur loads from the FIFO.
- FIFO non-empty: cur loads the FIFO head, which is popped.
- FIFO empty: cur loads 0 and underrun is set.
- A write in the same cycle is not bypassed to cur.
REQ-010 The modulator step on a load tick uses the newly loaded value, so each sample governs exactly DECIM consecutive ticks starting at its load tick.
REQ-011 Modulator (first-order, 16-bit phase accumulator acc):
- u = sample + 32768, unsigned 16-bit.
- s = acc + u, 17-bit.
- pdm_o is registered to s[16] on the tick.
- acc is updated to s[15:0] on the tick.
REQ-012 On non-tick cycles pdm_o, acc, phase and cur hold their values.
REQ-013 Long-run density of ones on pdm_o equals u/65536.
- sample -32768 gives all zeros.
- sample 0 gives 50 %.
REQ-014 level equals writes accepted minus pops since reset, and is always within 0..DEPTH.
REQ-015 A write and a pop in the same cycle leave level unchanged.
REQ-016 ready = (level != DEPTH), combinational from level.
REQ-017 underrun and overflow clear only on reset.

Reset
REQ-018 While reset=1, state takes these values on every clk edge:
- pdm_o=0, sclk_o=0, acc=0, cur=0, level=0, underrun=0, overflow=0.
- phase=DECIM-1, so that the first tick after reset is a load tick.
- edge register=0.
REQ-019 Reset asserted mid-stream discards all FIFO contents and any partly used sample.
- No tick is recognised in a cycle where reset=1.
REQ-020 dv_i is ignored while reset=1.

Structure
REQ-021 The shared package holds these constants:
- PCM_WIDTH=16.
- PDM_DECIM=125.
- PDM_OFFSET=32768.
- The FIFO depth default.
REQ-022 The FIFO is one sub-module, pcm_fifo, with these properties:
- Synchronous write and pop, and a head output.
- Count output.
- Same-cycle write and pop allowed when full.
REQ-023 The edge detect, phase counter, load mux and accumulator live in pdm_speaker_tx.
- Estimated size is about 200 RTL lines in total.

Verification
REQ-024 Reset; write 0x0000 once; apply 2 MHz sclk.
- Required: the first 4 tick outputs on pdm_o are 0,1,0,1.
- Required: underrun is still 0 after tick 125 if a second sample was written in time.
REQ-025 Write -32768 before the first tick; apply 125 ticks.
- Required: pdm_o is 0 on all 125 ticks.
REQ-026 Write 0x7FFF before the first tick; apply 125 ticks.
- Required: tick 1 output is 0 and ticks 2..125 are 1.
REQ-027 Write 5 samples back-to-back with no ticks.
- Required: level reaches 4 and ready=0.
- Required: the 5th write is dropped and overflow=1.
- Then write when full in the same cycle as a load tick: level stays 4 and overflow does not newly change.
REQ-028 Never write, then apply 1 tick.
- Required: underrun=1 and cur=0.
- Required: pdm_o then alternates 0,1,0,1 from reset.
REQ-029 Assert reset for 1 cycle mid-sample with level=3.
- Required: level=0 and pdm_o=0.
- Required: the next tick is a load tick.
- Required: both flags are cleared.
